// File: rtl/mem_access_sequencer.sv
// Arbitrates the shared memory bus between instruction fetch and load/store, running one
// fixed-length access at a time and returning a one-cycle done pulse with the read data.
module mem_access_sequencer #(
    parameter int unsigned WAIT_CYCLES   = 2,
    parameter int unsigned MAX_LS_STREAK = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_rw,
    input  logic [15:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [3:0] WaitLoad  = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] MaxStreak = 4'(MAX_LS_STREAK);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic        owner_ls_q, owner_ls_d;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  streak_q, streak_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_rw_q, mem_rw_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;

    logic grant_ls, grant_if;

    // LS wins a tie unless fetch has already lost MAX_LS_STREAK times in a row.
    assign grant_ls = ls_req && !(if_req && (streak_q == MaxStreak));
    assign grant_if = if_req && !grant_ls;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant_ls || grant_if) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (wait_q == 4'd0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        owner_ls_d  = owner_ls_q;
        wait_d      = wait_q;
        streak_d    = streak_q;
        if_done_d   = 1'b0;
        if_data_d   = if_data_q;
        ls_done_d   = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        mem_en_d    = mem_en_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            StIdle: begin
                if (grant_ls || grant_if) begin
                    owner_ls_d = grant_ls;
                    mem_en_d   = 1'b1;
                    mem_rw_d   = grant_ls && ls_rw;
                    mem_addr_d = grant_ls ? ls_addr : if_addr;
                    wait_d     = WaitLoad;
                    if (grant_ls) begin
                        mem_wdata_d = ls_wdata;
                    end
                    if (grant_ls && if_req) begin
                        streak_d = (streak_q == MaxStreak) ? MaxStreak : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                end
            end
            StAccess: begin
                if (wait_q == 4'd0) begin
                    mem_en_d = 1'b0;
                    mem_rw_d = 1'b0;
                    if (owner_ls_q) begin
                        ls_done_d = 1'b1;
                        if (!mem_rw_q) begin
                            ls_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = mem_rdata;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_ls_q  <= 1'b0;
            wait_q      <= 4'd0;
            streak_q    <= 4'd0;
            if_done_q   <= 1'b0;
            if_data_q   <= 32'd0;
            ls_done_q   <= 1'b0;
            ls_rdata_q  <= 32'd0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            owner_ls_q  <= owner_ls_d;
            wait_q      <= wait_d;
            streak_q    <= streak_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            ls_done_q   <= ls_done_d;
            ls_rdata_q  <= ls_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign ls_done   = ls_done_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
